// File: rtl/shot_pkg.sv
// Shared state encoding, widths and magnitude helper for the shot capture path.
package shot_pkg;

  localparam int STATE_W = 3;
  localparam int MAG_W   = 17;
  localparam int FLICK_W = 16;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    TRACK   = 3'd2,
    PRESENT = 3'd3,
    COOL    = 3'd4
  } state_t;

  // Widened sum so the combined magnitude can never wrap.
  function automatic logic [MAG_W-1:0] flick_mag(input logic [FLICK_W-1:0] x,
                                                 input logic [FLICK_W-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

endpackage

// File: rtl/flick_peak_tracker.sv
// Follows one flick: keeps the X/Y pair of its peak sample, its length and
// the run of released samples, and flags the sample that ends the flick.
module flick_peak_tracker
  import shot_pkg::*;
#(
  parameter logic [MAG_W-1:0] REL_THRESH  = 17'd100,
  parameter int               REL_COUNT   = 3,
  parameter int               MIN_SAMPLES = 4,
  parameter int               MAX_TRACK   = 64,
  localparam int              LEN_W       = $clog2(MAX_TRACK + 1),
  localparam int              REL_W       = $clog2(REL_COUNT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               load,
  input  logic               track,
  input  logic [FLICK_W-1:0] x_flick,
  input  logic [FLICK_W-1:0] y_flick,
  output logic [FLICK_W-1:0] shot_x,
  output logic [FLICK_W-1:0] shot_y,
  output logic [LEN_W-1:0]   len,
  output logic               flick_end,
  output logic               flick_long
);

  logic [MAG_W-1:0] mag;
  logic [MAG_W-1:0] peak;
  logic [REL_W-1:0] rel_cnt;
  logic [REL_W-1:0] rel_next;
  logic [LEN_W-1:0] len_next;

  assign mag = flick_mag(x_flick, y_flick);

  // Decisions are made on the post-increment counts so the ending sample itself counts.
  always_comb begin
    len_next = len;
    if (len < LEN_W'(MAX_TRACK)) len_next = len + 1'b1;
    rel_next = '0;
    if (mag < REL_THRESH) begin
      rel_next = rel_cnt;
      if (rel_cnt < REL_W'(REL_COUNT)) rel_next = rel_cnt + 1'b1;
    end
    flick_end  = track && ((rel_next >= REL_W'(REL_COUNT)) ||
                           (len_next >= LEN_W'(MAX_TRACK)));
    flick_long = (len_next >= LEN_W'(MIN_SAMPLES));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak    <= '0;
      shot_x  <= '0;
      shot_y  <= '0;
      len     <= '0;
      rel_cnt <= '0;
    end else if (clear) begin
      len     <= '0;
      rel_cnt <= '0;
    end else if (load) begin
      peak    <= mag;
      shot_x  <= x_flick;
      shot_y  <= y_flick;
      len     <= LEN_W'(1);
      rel_cnt <= '0;
    end else if (track) begin
      len     <= len_next;
      rel_cnt <= rel_next;
      // Strictly greater, so on a tie the earlier peak sample is kept.
      if (mag > peak) begin
        peak   <= mag;
        shot_x <= x_flick;
        shot_y <= y_flick;
      end
    end
  end

endmodule

// File: rtl/shot_capture_ctrl.sv
// Shot capture sequencer: arms on request, triggers on a strong flick, tracks it
// to release and presents the peak X/Y to the game logic over valid/ready.
module shot_capture_ctrl
  import shot_pkg::*;
#(
  parameter logic [MAG_W-1:0] TRIG_THRESH = 17'd200,
  parameter logic [MAG_W-1:0] REL_THRESH  = 17'd100,
  parameter int               REL_COUNT   = 3,
  parameter int               MIN_SAMPLES = 4,
  parameter int               MAX_TRACK   = 64,
  parameter int               ARM_TIMEOUT = 4096,
  parameter int               COOLDOWN    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arm,
  input  logic               abort,
  input  logic               sample_valid,
  input  logic [FLICK_W-1:0] x_flick,
  input  logic [FLICK_W-1:0] y_flick,
  output logic               shot_valid,
  input  logic               shot_ready,
  output logic [FLICK_W-1:0] shot_x,
  output logic [FLICK_W-1:0] shot_y,
  output logic [6:0]         shot_len,
  output logic [STATE_W-1:0] state,
  output logic               timeout,
  output logic               reject
);

  localparam int LEN_W = $clog2(MAX_TRACK + 1);
  localparam int TO_W  = $clog2(ARM_TIMEOUT + 1);
  localparam int CL_W  = $clog2(COOLDOWN + 1);

  state_t           state_q;
  state_t           state_d;
  logic [TO_W-1:0]  to_cnt;
  logic [TO_W-1:0]  to_next;
  logic [CL_W-1:0]  cool_cnt;
  logic [CL_W-1:0]  cool_next;
  logic             timeout_d;
  logic             reject_d;
  logic             load;
  logic             track;
  logic [MAG_W-1:0] mag;
  logic [LEN_W-1:0] len;
  logic             flick_end;
  logic             flick_long;

  assign mag        = flick_mag(x_flick, y_flick);
  assign state      = state_q;
  assign shot_valid = (state_q == PRESENT);
  assign shot_len   = 7'(len);

  flick_peak_tracker #(
    .REL_THRESH (REL_THRESH),
    .REL_COUNT  (REL_COUNT),
    .MIN_SAMPLES(MIN_SAMPLES),
    .MAX_TRACK  (MAX_TRACK)
  ) u_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (abort),
    .load      (load),
    .track     (track),
    .x_flick   (x_flick),
    .y_flick   (y_flick),
    .shot_x    (shot_x),
    .shot_y    (shot_y),
    .len       (len),
    .flick_end (flick_end),
    .flick_long(flick_long)
  );

  // abort outranks everything; within ARMED a trigger outranks arm and timeout.
  always_comb begin
    state_d   = state_q;
    to_next   = to_cnt;
    cool_next = cool_cnt;
    timeout_d = 1'b0;
    reject_d  = 1'b0;
    load      = 1'b0;
    track     = 1'b0;
    if (abort) begin
      state_d   = IDLE;
      to_next   = '0;
      cool_next = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arm) begin
            state_d = ARMED;
            to_next = '0;
          end
        end
        ARMED: begin
          if (sample_valid && (mag >= TRIG_THRESH)) begin
            load    = 1'b1;
            state_d = TRACK;
            to_next = '0;
          end else if (arm) begin
            to_next = '0;
          end else if (sample_valid) begin
            if (to_cnt >= TO_W'(ARM_TIMEOUT - 1)) begin
              timeout_d = 1'b1;
              state_d   = IDLE;
              to_next   = '0;
            end else begin
              to_next = to_cnt + 1'b1;
            end
          end
        end
        TRACK: begin
          if (sample_valid) begin
            track = 1'b1;
            if (flick_end) begin
              if (flick_long) begin
                state_d = PRESENT;
              end else begin
                reject_d = 1'b1;
                state_d  = ARMED;
                to_next  = '0;
              end
            end
          end
        end
        PRESENT: begin
          if (shot_ready) begin
            state_d   = COOL;
            cool_next = '0;
          end
        end
        COOL: begin
          if (sample_valid) begin
            if (cool_cnt >= CL_W'(COOLDOWN - 1)) begin
              state_d   = IDLE;
              cool_next = '0;
            end else begin
              cool_next = cool_cnt + 1'b1;
            end
          end
        end
        default: begin
          state_d   = IDLE;
          to_next   = '0;
          cool_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      to_cnt   <= '0;
      cool_cnt <= '0;
      timeout  <= 1'b0;
      reject   <= 1'b0;
    end else begin
      state_q  <= state_d;
      to_cnt   <= to_next;
      cool_cnt <= cool_next;
      timeout  <= timeout_d;
      reject   <= reject_d;
    end
  end

endmodule

// File: tb/tb_shot_capture_ctrl.sv
// Directed bench for shot_capture_ctrl: default build plus MIN_SAMPLES=5 and
// MAX_TRACK=8 builds driven from the same stimulus.
module tb_shot_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic        sample_valid = 1'b0;
  logic        shot_ready = 1'b0;
  logic [15:0] x_flick = '0;
  logic [15:0] y_flick = '0;

  logic        d_valid, m_valid, t_valid;
  logic [15:0] d_x, d_y, m_x, m_y, t_x, t_y;
  logic [6:0]  d_len, m_len, t_len;
  logic [2:0]  d_state, m_state, t_state;
  logic        d_timeout, m_timeout, t_timeout;
  logic        d_reject, m_reject, t_reject;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  shot_capture_ctrl dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort),
    .sample_valid(sample_valid), .x_flick(x_flick), .y_flick(y_flick),
    .shot_valid(d_valid), .shot_ready(shot_ready), .shot_x(d_x), .shot_y(d_y),
    .shot_len(d_len), .state(d_state), .timeout(d_timeout), .reject(d_reject)
  );

  shot_capture_ctrl #(.MIN_SAMPLES(5)) dut_min5 (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort),
    .sample_valid(sample_valid), .x_flick(x_flick), .y_flick(y_flick),
    .shot_valid(m_valid), .shot_ready(shot_ready), .shot_x(m_x), .shot_y(m_y),
    .shot_len(m_len), .state(m_state), .timeout(m_timeout), .reject(m_reject)
  );

  shot_capture_ctrl #(.MAX_TRACK(8)) dut_max8 (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort),
    .sample_valid(sample_valid), .x_flick(x_flick), .y_flick(y_flick),
    .shot_valid(t_valid), .shot_ready(shot_ready), .shot_x(t_x), .shot_y(t_y),
    .shot_len(t_len), .state(t_state), .timeout(t_timeout), .reject(t_reject)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y);
    sample_valid = 1'b1;
    x_flick = x;
    y_flick = y;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic pulseArm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic pulseAbort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_state", 32'(d_state), 0);
    checkOutput("reset_valid", 32'(d_valid), 0);
    checkOutput("reset_x", 32'(d_x), 0);
    checkOutput("reset_len", 32'(d_len), 0);
    checkOutput("reset_timeout", 32'(d_timeout), 0);
    checkOutput("reset_reject", 32'(d_reject), 0);
    #4 rst_n = 1'b1;
    step();

    $display("[TB] trigger and peak capture");
    pulseArm();
    checkOutput("armed", 32'(d_state), 1);
    applyStimulus(50, 50);
    checkOutput("below_trigger", 32'(d_state), 1);
    applyStimulus(120, 100);
    checkOutput("track_start", 32'(d_state), 2);
    checkOutput("track_first_x", 32'(d_x), 120);
    applyStimulus(300, 200);
    applyStimulus(150, 100);
    applyStimulus(20, 10);
    applyStimulus(10, 10);
    checkOutput("still_track", 32'(d_state), 2);
    checkOutput("no_valid_yet", 32'(d_valid), 0);
    applyStimulus(5, 5);
    checkOutput("present", 32'(d_state), 3);
    checkOutput("shot_valid", 32'(d_valid), 1);
    checkOutput("shot_x", 32'(d_x), 300);
    checkOutput("shot_y", 32'(d_y), 200);
    checkOutput("shot_len", 32'(d_len), 6);

    $display("[TB] handshake hold and cooldown");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(400, 400);
      checkOutput("hold_valid", 32'(d_valid), 1);
      checkOutput("hold_x", 32'(d_x), 300);
      checkOutput("hold_len", 32'(d_len), 6);
    end
    shot_ready = 1'b1;
    step();
    shot_ready = 1'b0;
    checkOutput("valid_dropped", 32'(d_valid), 0);
    checkOutput("cool", 32'(d_state), 4);
    checkOutput("data_held_x", 32'(d_x), 300);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(0, 0);
      if (i == 30) checkOutput("cool_31", 32'(d_state), 4);
    end
    checkOutput("cool_done", 32'(d_state), 0);

    $display("[TB] short flick");
    pulseArm();
    applyStimulus(200, 50);
    applyStimulus(10, 0);
    applyStimulus(10, 0);
    applyStimulus(10, 0);
    checkOutput("short_accept_state", 32'(d_state), 3);
    checkOutput("short_accept_len", 32'(d_len), 4);
    checkOutput("short_accept_reject", 32'(d_reject), 0);
    checkOutput("min5_reject", 32'(m_reject), 1);
    checkOutput("min5_state", 32'(m_state), 1);
    checkOutput("min5_valid", 32'(m_valid), 0);
    step();
    checkOutput("min5_reject_once", 32'(m_reject), 0);
    checkOutput("min5_still_armed", 32'(m_state), 1);

    $display("[TB] abort in present");
    pulseAbort();
    checkOutput("abort_valid", 32'(d_valid), 0);
    checkOutput("abort_state", 32'(d_state), 0);

    $display("[TB] tie keeps earlier sample");
    pulseArm();
    applyStimulus(250, 50);
    applyStimulus(50, 250);
    checkOutput("tie_x", 32'(d_x), 250);
    checkOutput("tie_y", 32'(d_y), 50);
    pulseAbort();

    $display("[TB] max track");
    pulseArm();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(150, 150);
      if (i == 6) checkOutput("max8_track7", 32'(t_state), 2);
      if (i == 7) begin
        checkOutput("max8_present", 32'(t_state), 3);
        checkOutput("max8_len", 32'(t_len), 8);
      end
    end
    checkOutput("max8_len_held", 32'(t_len), 8);
    checkOutput("max8_x", 32'(t_x), 150);
    checkOutput("max8_y", 32'(t_y), 150);
    checkOutput("default_still_track", 32'(d_state), 2);
    checkOutput("default_len10", 32'(d_len), 10);
    pulseAbort();

    $display("[TB] arm timeout");
    pulseArm();
    pulses = 0;
    for (int i = 0; i < 4096; i++) begin
      applyStimulus(0, 0);
      if (d_timeout) pulses++;
      if (i == 4094) checkOutput("armed_4095", 32'(d_state), 1);
    end
    checkOutput("timeout_pulse", 32'(d_timeout), 1);
    checkOutput("timeout_idle", 32'(d_state), 0);
    step();
    if (d_timeout) pulses++;
    checkOutput("timeout_count", 32'(pulses), 1);

    $display("[TB] trigger on last sample before timeout");
    pulseArm();
    pulses = 0;
    for (int i = 0; i < 4095; i++) begin
      applyStimulus(0, 0);
      if (d_timeout) pulses++;
    end
    applyStimulus(150, 100);
    if (d_timeout) pulses++;
    checkOutput("late_trigger_state", 32'(d_state), 2);
    checkOutput("late_trigger_no_timeout", 32'(pulses), 0);
    applyStimulus(300, 200);
    checkOutput("late_trigger_peak_x", 32'(d_x), 300);

    $display("[TB] async reset mid track");
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_state", 32'(d_state), 0);
    checkOutput("rst_x", 32'(d_x), 0);
    checkOutput("rst_y", 32'(d_y), 0);
    checkOutput("rst_len", 32'(d_len), 0);
    checkOutput("rst_valid", 32'(d_valid), 0);
    #1 rst_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
